// File: rtl/controle_turno.sv
// Turn controller and shot arbiter for the two-player naval game attack datapath.
// Optional turn timeout is built in when the TURN_TIMEOUT_EN macro is defined.
module controle_turno #(
    parameter int MAX_SHOTS   = 15,
    parameter int TIMEOUT_CYC = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       map_load,
    input  logic [4:0] map_p1,
    input  logic [4:0] map_p2,
    input  logic       start,
    input  logic       shot_valid,
    input  logic       shot_player,
    input  logic [4:0] shot_pos,
    output logic       shot_ready,
    output logic       turn,
    output logic       hit_valid,
    output logic       hit,
    output logic       err,
    output logic [4:0] hits_p1,
    output logic [4:0] hits_p2,
    output logic       game_over,
    output logic       winner,
    output logic       draw,
    output logic       timeout
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TURN      = 2'd1,
        CHECK     = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    localparam logic [4:0] MAX_CNT  = 5'(MAX_SHOTS);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    function automatic logic is_onehot(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    state_t     state_r, next_state_s;
    logic [4:0] map1_r, map2_r, mask1_r, mask2_r, hits1_r, hits2_r;
    logic [4:0] cnt1_r, cnt2_r;
    logic       turn_r, hit_valid_r, hit_r, err_r, game_over_r, winner_r, draw_r;
    logic       timeout_r, shot_ready_r, hold_r;

    logic [4:0] fire_mask_s, opp_map_s, fire_hits_s, other_cnt_s;
    logic       accept_s, bad_s, strike_s, tmo_s, win_s, both_full_s, other_full_s;
    logic       load_s, clear_s, end_win_s, end_draw_s, pass_s;

    // Everything below is seen from the point of view of the player holding the turn.
    assign fire_mask_s  = turn_r ? mask2_r : mask1_r;
    assign opp_map_s    = turn_r ? map1_r  : map2_r;
    assign fire_hits_s  = turn_r ? hits2_r : hits1_r;
    assign other_cnt_s  = turn_r ? cnt1_r  : cnt2_r;
    assign accept_s     = (state_r == TURN) && shot_valid && (shot_player == turn_r);
    assign bad_s        = !is_onehot(shot_pos) || ((shot_pos & fire_mask_s) != 5'd0);
    assign strike_s     = !bad_s && ((shot_pos & opp_map_s) != 5'd0);
    assign win_s        = (fire_hits_s == opp_map_s);
    assign both_full_s  = (cnt1_r == MAX_CNT) && (cnt2_r == MAX_CNT);
    assign other_full_s = (other_cnt_s == MAX_CNT);

`ifdef TURN_TIMEOUT_EN
    logic [7:0] tmo_cnt_r;

    // idle-cycle counter; any stay outside TURN restarts it from zero
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= 8'd0;
        end else if (state_r != TURN) begin
            tmo_cnt_r <= 8'd0;
        end else if (!accept_s) begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    assign tmo_s = (state_r == TURN) && !accept_s && (tmo_cnt_r == TMO_LAST);
`else
    logic unused_tmo_s;
    assign unused_tmo_s = ^TMO_LAST;
    assign tmo_s        = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // next-state decode and datapath control strobes
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        clear_s      = 1'b0;
        end_win_s    = 1'b0;
        end_draw_s   = 1'b0;
        pass_s       = 1'b0;
        case (state_r)
            IDLE: begin
                // a load in the same cycle as start wins; start is dropped
                if (map_load) begin
                    load_s = 1'b1;
                end else if (start && (map1_r != 5'd0) && (map2_r != 5'd0)) begin
                    clear_s      = 1'b1;
                    next_state_s = TURN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            TURN: begin
                if (accept_s || tmo_s) begin
                    next_state_s = CHECK;
                end else begin
                    next_state_s = TURN;
                end
            end
            CHECK: begin
                if (win_s) begin
                    end_win_s    = 1'b1;
                    next_state_s = GAME_OVER;
                end else if (both_full_s) begin
                    end_draw_s   = 1'b1;
                    next_state_s = GAME_OVER;
                end else begin
                    pass_s       = !hold_r && !other_full_s;
                    next_state_s = TURN;
                end
            end
            GAME_OVER: begin
                if (start) begin
                    clear_s      = 1'b1;
                    next_state_s = TURN;
                end else begin
                    next_state_s = GAME_OVER;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // maps, shot bookkeeping and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            map1_r       <= 5'd0;
            map2_r       <= 5'd0;
            mask1_r      <= 5'd0;
            mask2_r      <= 5'd0;
            hits1_r      <= 5'd0;
            hits2_r      <= 5'd0;
            cnt1_r       <= 5'd0;
            cnt2_r       <= 5'd0;
            turn_r       <= 1'b0;
            hit_valid_r  <= 1'b0;
            hit_r        <= 1'b0;
            err_r        <= 1'b0;
            game_over_r  <= 1'b0;
            winner_r     <= 1'b0;
            draw_r       <= 1'b0;
            timeout_r    <= 1'b0;
            shot_ready_r <= 1'b0;
            hold_r       <= 1'b0;
        end else begin
            shot_ready_r <= (next_state_s == TURN);
            hit_valid_r  <= accept_s;
            timeout_r    <= tmo_s;
            if (load_s) begin
                map1_r <= map_p1;
                map2_r <= map_p2;
            end
            if (clear_s) begin
                mask1_r     <= 5'd0;
                mask2_r     <= 5'd0;
                hits1_r     <= 5'd0;
                hits2_r     <= 5'd0;
                cnt1_r      <= 5'd0;
                cnt2_r      <= 5'd0;
                turn_r      <= 1'b0;
                hit_r       <= 1'b0;
                err_r       <= 1'b0;
                game_over_r <= 1'b0;
                winner_r    <= 1'b0;
                draw_r      <= 1'b0;
                hold_r      <= 1'b0;
            end
            if (accept_s) begin
                hit_r  <= strike_s;
                err_r  <= bad_s;
                hold_r <= bad_s;
                // a rejected shot leaves mask, hits and count untouched
                if (!bad_s && turn_r) begin
                    mask2_r <= mask2_r | shot_pos;
                    cnt2_r  <= cnt2_r + 5'd1;
                    hits2_r <= strike_s ? (hits2_r | shot_pos) : hits2_r;
                end else if (!bad_s) begin
                    mask1_r <= mask1_r | shot_pos;
                    cnt1_r  <= cnt1_r + 5'd1;
                    hits1_r <= strike_s ? (hits1_r | shot_pos) : hits1_r;
                end
            end
            if (tmo_s) begin
                hold_r <= 1'b0;
                if (turn_r) begin
                    cnt2_r <= cnt2_r + 5'd1;
                end else begin
                    cnt1_r <= cnt1_r + 5'd1;
                end
            end
            if (end_win_s) begin
                game_over_r <= 1'b1;
                winner_r    <= turn_r;
            end
            if (end_draw_s) begin
                game_over_r <= 1'b1;
                draw_r      <= 1'b1;
            end
            if (pass_s) begin
                turn_r <= !turn_r;
            end
        end
    end

    assign shot_ready = shot_ready_r;
    assign turn       = turn_r;
    assign hit_valid  = hit_valid_r;
    assign hit        = hit_r;
    assign err        = err_r;
    assign hits_p1    = hits1_r;
    assign hits_p2    = hits2_r;
    assign game_over  = game_over_r;
    assign winner     = winner_r;
    assign draw       = draw_r;
    assign timeout    = timeout_r;
endmodule

// File: tb/tb_controle_turno.sv
// Directed plus randomized bench for controle_turno against a transaction-level game model.
`timescale 1ns/1ps
module tb_controle_turno;
    localparam int MAXS = 3;
`ifdef TURN_TIMEOUT_EN
    localparam int TMO = 5;
`else
    localparam int TMO = 50;
`endif

    logic       clk = 1'b0;
    logic       rst, map_load, start, shot_valid, shot_player;
    logic [4:0] map_p1, map_p2, shot_pos;
    logic       shot_ready, turn, hit_valid, hit, err, game_over, winner, draw, timeout;
    logic [4:0] hits_p1, hits_p2;

    controle_turno #(.MAX_SHOTS(MAXS), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .map_load(map_load), .map_p1(map_p1), .map_p2(map_p2),
        .start(start), .shot_valid(shot_valid), .shot_player(shot_player), .shot_pos(shot_pos),
        .shot_ready(shot_ready), .turn(turn), .hit_valid(hit_valid), .hit(hit), .err(err),
        .hits_p1(hits_p1), .hits_p2(hits_p2), .game_over(game_over), .winner(winner),
        .draw(draw), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // game model: index 0 = P1, 1 = P2; phase 0 idle, 1 playing, 2 over
    logic [4:0] m_map [2];
    logic [4:0] m_hits[2];
    logic [4:0] m_mask[2];
    int         m_cnt [2];
    int         m_phase;
    logic       m_turn, m_win, m_draw;
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        n_vec++;
        assert (obs_v === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".shot_ready"}, shot_ready, m_phase == 1);
        chk({tag, ".turn"}, turn, m_turn);
        chk({tag, ".game_over"}, game_over, m_phase == 2);
        chk({tag, ".winner"}, winner, m_win);
        chk({tag, ".draw"}, draw, m_draw);
        chk({tag, ".hits_p1"}, hits_p1, m_hits[0]);
        chk({tag, ".hits_p2"}, hits_p2, m_hits[1]);
        chk({tag, ".hit_valid"}, hit_valid, 1'b0);
        chk({tag, ".timeout"}, timeout, 1'b0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_hits[i] = 5'd0;
            m_mask[i] = 5'd0;
            m_cnt[i]  = 0;
        end
        m_turn = 1'b0;
        m_win  = 1'b0;
        m_draw = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_clear();
        m_map[0] = 5'd0;
        m_map[1] = 5'd0;
        m_phase  = 0;
        check_all("reset");
        chk("reset.hit", hit, 1'b0);
        chk("reset.err", err, 1'b0);
    endtask

    task automatic do_start(input logic with_load, input logic [4:0] p1, input logic [4:0] p2);
        start    = 1'b1;
        map_load = with_load;
        map_p1   = p1;
        map_p2   = p2;
        @(negedge clk);
        start    = 1'b0;
        map_load = 1'b0;
        if (m_phase == 0 && with_load) begin
            m_map[0] = p1;
            m_map[1] = p2;
        end else if ((m_phase == 0 && m_map[0] != 5'd0 && m_map[1] != 5'd0) || m_phase == 2) begin
            model_clear();
            m_phase = 1;
        end
        check_all("start");
    endtask

    task automatic do_load(input logic [4:0] p1, input logic [4:0] p2);
        map_load = 1'b1;
        map_p1   = p1;
        map_p2   = p2;
        @(negedge clk);
        map_load = 1'b0;
        if (m_phase == 0) begin
            m_map[0] = p1;
            m_map[1] = p2;
        end
        check_all("load");
    endtask

    // end-of-shot rules: win, then draw, then pass the turn unless the other side is out
    task automatic model_settle(input logic p, input logic kept);
        int o;
        o = (p == 1'b1) ? 0 : 1;
        if (m_hits[p] == m_map[o]) begin
            m_phase = 2;
            m_win   = p;
        end else if (m_cnt[0] == MAXS && m_cnt[1] == MAXS) begin
            m_phase = 2;
            m_draw  = 1'b1;
        end else if (!kept && m_cnt[o] < MAXS) begin
            m_turn = ~p;
        end
    endtask

    task automatic fire(input logic p, input logic [4:0] pos, input string tag);
        logic bad, strike;
        int   o;
        shot_valid  = 1'b1;
        shot_player = p;
        shot_pos    = pos;
        @(negedge clk);
        shot_valid = 1'b0;
        if (m_phase == 1 && p == m_turn) begin
            o      = (p == 1'b1) ? 0 : 1;
            bad    = ($countones(pos) != 1) || ((pos & m_mask[p]) != 5'd0);
            strike = !bad && ((pos & m_map[o]) != 5'd0);
            if (!bad) begin
                m_mask[p] = m_mask[p] | pos;
                m_cnt[p]  = m_cnt[p] + 1;
                if (strike) m_hits[p] = m_hits[p] | pos;
            end
            chk({tag, ".hit_valid"}, hit_valid, 1'b1);
            chk({tag, ".hit"}, hit, strike);
            chk({tag, ".err"}, err, bad);
            chk({tag, ".hits_p1"}, hits_p1, m_hits[0]);
            chk({tag, ".hits_p2"}, hits_p2, m_hits[1]);
            chk({tag, ".ready_low"}, shot_ready, 1'b0);
            model_settle(p, bad);
            @(negedge clk);
        end
        check_all(tag);
    endtask

    initial begin
        logic       p, last_wrong;
        logic [4:0] pos, r1, r2;
        rst = 1'b1; map_load = 1'b0; start = 1'b0; shot_valid = 1'b0;
        shot_player = 1'b0; map_p1 = 5'd0; map_p2 = 5'd0; shot_pos = 5'd0;

        do_reset();
        do_start(1'b0, 5'd0, 5'd0);               // empty maps: start ignored
        do_load(5'b00011, 5'b10100);
        do_start(1'b0, 5'd0, 5'd0);
        fire(1'b0, 5'b00100, "p1_hit");
        fire(1'b0, 5'b00001, "p1_wrong_turn");
        fire(1'b1, 5'b00110, "p2_not_onehot");
        fire(1'b1, 5'b01000, "p2_miss");
        fire(1'b0, 5'b00010, "p1_miss");
        fire(1'b1, 5'b01000, "p2_repeat");
        fire(1'b1, 5'b10000, "p2_miss2");
        fire(1'b0, 5'b10000, "p1_win");
        fire(1'b1, 5'b00001, "shot_in_over");
        do_load(5'b11111, 5'b11111);              // ignored in GAME_OVER
        do_start(1'b0, 5'd0, 5'd0);

        // all misses until both players run out of shots
        fire(1'b0, 5'b00001, "d1");
        fire(1'b1, 5'b00100, "d2");
        fire(1'b0, 5'b00010, "d3");
        fire(1'b1, 5'b01000, "d4");
        fire(1'b0, 5'b01000, "d5");
        fire(1'b1, 5'b10000, "d6");
        chk("draw_reached", draw, 1'b1);
        do_start(1'b0, 5'd0, 5'd0);

        // reset while the shot is being checked
        shot_valid = 1'b1; shot_player = 1'b0; shot_pos = 5'b00100;
        @(negedge clk);
        shot_valid = 1'b0;
        chk("midcheck.hit_valid", hit_valid, 1'b1);
        do_reset();

        do_start(1'b1, 5'b01001, 5'b00110);       // load wins over start
        do_start(1'b0, 5'd0, 5'd0);

`ifdef TURN_TIMEOUT_EN
        for (int i = 0; i < TMO - 1; i++) begin
            @(negedge clk);
            chk("tmo.early", timeout, 1'b0);
        end
        @(negedge clk);
        chk("tmo.pulse", timeout, 1'b1);
        chk("tmo.no_hit_valid", hit_valid, 1'b0);
        m_cnt[0] = m_cnt[0] + 1;
        model_settle(1'b0, 1'b0);
        @(negedge clk);
        check_all("tmo.after");
`endif

        for (int g = 0; g < 25; g++) begin
            do_reset();
            r1 = 5'($urandom);
            r2 = 5'($urandom);
            if (r1 == 5'd0) r1 = 5'b00001;
            if (r2 == 5'd0) r2 = 5'b10000;
            do_load(r1, r2);
            do_start(1'b0, 5'd0, 5'd0);
            last_wrong = 1'b0;
            for (int s = 0; s < 60 && m_phase == 1; s++) begin
                if (last_wrong) p = m_turn;
                else p = ($urandom_range(0, 3) == 0) ? ~m_turn : m_turn;
                last_wrong = (p != m_turn);
                if ($urandom_range(0, 3) == 0) pos = 5'($urandom);
                else pos = 5'd1 << $urandom_range(0, 4);
                fire(p, pos, "rand");
            end
            if (m_phase == 2 && $urandom_range(0, 1) == 1) do_start(1'b0, 5'd0, 5'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/controle_turno.md
# controle_turno

Turn controller and arbiter for the attack-verification datapath of the two-player naval game. It holds both players' 5-cell ship maps and decides whose turn it is. It accepts one shot at a time from the player whose turn it is, scores the shot against the opponent's map, and keeps sticky per-player hit registers. It also detects win, draw and, optionally, turn timeout. It sits between the player input logic and the display/score logic.

## Interface
Parameters:
- MAX_SHOTS, 15: valid shots each player may fire; range 1..31.
- TIMEOUT_CYC, 50: cycles a player may idle in its turn; used only with TURN_TIMEOUT_EN; range 2..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- map_load  in  1  latches map_p1/map_p2; honoured only in IDLE.
- map_p1  in  5  player 1 ship cells; bit i = cell i occupied.
- map_p2  in  5  player 2 ship cells.
- start  in  1  begins a game from IDLE or GAME_OVER.
- shot_valid  in  1  shot request.
- shot_player  in  1  requester: 0 = P1, 1 = P2.
- shot_pos  in  5  target cell; must be one-hot.
- shot_ready  out  1  high only in TURN.
- turn  out  1  player allowed to fire.
- hit_valid  out  1  one-cycle pulse; result of the accepted shot.
- hit  out  1  accepted shot struck a ship; qualified by hit_valid.
- err  out  1  accepted shot rejected (bad position); qualified by hit_valid.
- hits_p1  out  5  cells of map_p2 hit by P1 (sticky).
- hits_p2  out  5  cells of map_p1 hit by P2 (sticky).
- game_over  out  1  level; high in GAME_OVER.
- winner  out  1  valid when game_over & ~draw.
- draw  out  1  both players out of shots, no winner.
- timeout  out  1  one-cycle pulse when a turn expires.

## Operation
- States: IDLE, TURN, CHECK, GAME_OVER.
- Reset: state IDLE; maps = 0. Every output is 0, including turn.
- IDLE:
  - map_load copies both maps.
  - start moves to TURN with turn = 0. It requires both stored maps to be non-zero; otherwise start is ignored.
  - On the transition, hits, shot counters and flags are cleared.
  - If start and map_load arrive together, the new maps are loaded and start is ignored.
- TURN: accept = shot_valid & shot_ready & (shot_player == turn). A request from the wrong player has no effect.
- Scoring on the accept edge, with F = bits already set in the firing player's hit register plus previous misses tracked in that player's shot mask:
  - shot_pos not one-hot, or already in the firing player's shot mask: err = 1, hit = 0. No shot is consumed and the turn stays; state returns to TURN after CHECK.
  - Otherwise: hit = |(shot_pos & opponent map). The shot mask ORs in shot_pos. If hit, the hit register ORs in shot_pos. The player's shot count increments.
- CHECK (one cycle):
  - If the firing player's hits equal the opponent map: GAME_OVER, winner = firing player.
  - Else, if both shot counts equal MAX_SHOTS: GAME_OVER, draw = 1.
  - Else: turn toggles on valid shots (held on err) and state returns to TURN.
  - If a player has used all its shots, its turn is skipped: turn stays with the other player.
- GAME_OVER: all results are held. start restarts with the same maps (clear as above). map_load is ignored.

## Timing
- Shot accepted at edge N; hit_valid/hit/err/hits_* are updated at edge N.
- State is CHECK during the cycle after edge N, and shot_ready is low.
- turn, game_over, winner and draw are updated at edge N+1.
- Maximum throughput is one shot per 2 cycles.
- rst in any state overrides everything at the next edge. A shot in flight is discarded.

## Configuration
- TURN_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to TURN and counts each cycle in TURN without an accept.
  - When the count reaches TIMEOUT_CYC, timeout pulses, the idle player's shot count increments, and state goes to CHECK; there is no hit_valid pulse.
- TURN_TIMEOUT_EN undefined: TURN waits indefinitely and timeout is tied to 0.

## Test plan
- Reset, then map_load map_p1=5'b00011, map_p2=5'b10100, then start -> state TURN, turn=0, shot_ready=1, all results 0.
- P1 fires 5'b00100 -> hit_valid=1, hit=1, hits_p1=5'b00100; two cycles later turn=1. A P1 request while turn=1 -> no response.
- Error cases: P2 fires 5'b00110 -> err=1, turn stays 1. P2 repeats an earlier cell -> err=1, shot count unchanged.
- P1 hits 5'b00100 then 5'b10000, P2 missing in between -> after the second hit, game_over=1, winner=0, and shot_ready stays 0 until start.
- MAX_SHOTS=2, all misses -> after 4 valid shots, game_over=1, draw=1. A start then clears the hit registers and sets turn=0.
- With TURN_TIMEOUT_EN and TIMEOUT_CYC=5: P1 idles -> timeout pulses at the 5th idle cycle and turn=1 one cycle later. rst mid-CHECK -> IDLE and all outputs 0.
